bsg_parallel_in_serial_out_passthrough_dynamic: RTL and testbench

Converts one wide multi-word message into a stream of narrow words, with a per-message length. It is the transmit-side partner of the serial-in/parallel-out passthrough on narrow links.

---
 rtl/bsg_parallel_in_serial_out_passthrough_dynamic_pkg.sv | 9 +
 rtl/bsg_parallel_in_serial_out_passthrough_dynamic_mux.sv | 18 +
 rtl/bsg_parallel_in_serial_out_passthrough_dynamic.sv | 73 +++++++
 tb/tb_bsg_parallel_in_serial_out_passthrough_dynamic.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_parallel_in_serial_out_passthrough_dynamic_pkg.sv
// Shared width helpers for the parallel-in serial-out passthrough.
package bsg_parallel_in_serial_out_passthrough_dynamic_pkg;

  // Field width that stays at least one bit, even for a single-element range.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_parallel_in_serial_out_passthrough_dynamic_mux.sv
// One-of-els_p word selector over a packed multi-word bus.
module bsg_parallel_in_serial_out_passthrough_dynamic_mux
  import bsg_parallel_in_serial_out_passthrough_dynamic_pkg::*;
  #(parameter int width_p = 8,
    parameter int els_p = 4,
    localparam int lg_els_lp = safe_clog2(els_p))
  (input  logic [els_p*width_p-1:0] data_i,
   input  logic [lg_els_lp-1:0]     sel_i,
   output logic [width_p-1:0]       data_o);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < els_p; i++) begin
      if (sel_i == lg_els_lp'(i)) data_o = data_i[i*width_p +: width_p];
    end
  end

endmodule

// File: rtl/bsg_parallel_in_serial_out_passthrough_dynamic.sv
// Streams one held wide message out as narrow words; the wide input is
// acknowledged in the same cycle its last word is accepted downstream.
module bsg_parallel_in_serial_out_passthrough_dynamic
  import bsg_parallel_in_serial_out_passthrough_dynamic_pkg::*;
  #(parameter int width_p = 8,
    parameter int els_p = 4,
    parameter bit hi_to_lo_p = 1'b0,
    localparam int lg_els_lp = safe_clog2(els_p))
  (input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     v_i,
   input  logic [lg_els_lp-1:0]     len_i,
   input  logic [els_p*width_p-1:0] data_i,
   output logic                     ready_and_o,
   output logic                     v_o,
   output logic [width_p-1:0]       data_o,
   output logic                     first_o,
   output logic                     last_o,
   input  logic                     ready_and_i);

  logic [lg_els_lp-1:0] count_q;
  logic [lg_els_lp-1:0] sel;
  logic                 send;

  assign v_o         = v_i;
  assign send        = v_i & ready_and_i;
  assign first_o     = (count_q == '0);
  assign ready_and_o = send & last_o;

  if (els_p == 1) begin : g_single
    // Every message is one word; no counter, and len_i carries no information.
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, reset_i, len_i};
    assign count_q = '0;
    assign last_o  = 1'b1;
    assign sel     = '0;
  end else begin : g_multi
    logic [lg_els_lp-1:0] count_d;

    always_comb begin
      count_d = count_q;
      if (send) count_d = last_o ? '0 : count_q + lg_els_lp'(1);
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) count_q <= '0;
      else         count_q <= count_d;
    end

    assign last_o = (count_q == len_i);
    // Cannot underflow: count_q never passes len_i while a message is held.
    assign sel    = hi_to_lo_p ? (len_i - count_q) : count_q;

`ifndef SYNTHESIS
    a_len_legal: assert property (@(posedge clk_i) disable iff (reset_i)
      v_i |-> (int'(len_i) <= els_p - 1));
    a_input_stable: assert property (@(posedge clk_i) disable iff (reset_i)
      (v_i & ~ready_and_o) |=> ($stable(len_i) && $stable(data_i)));
    a_count_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
      v_i |-> (count_q <= len_i));
`endif
  end

  bsg_parallel_in_serial_out_passthrough_dynamic_mux #(
    .width_p(width_p),
    .els_p  (els_p)
  ) u_mux (
    .data_i(data_i),
    .sel_i (sel),
    .data_o(data_o)
  );

endmodule

// File: tb/tb_bsg_parallel_in_serial_out_passthrough_dynamic.sv
// Bench for the PISO passthrough: lo-to-hi, hi-to-lo and single-element builds.
module tb_bsg_parallel_in_serial_out_passthrough_dynamic;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  // DUT A: els 4, lo-to-hi
  logic va, rdya, ra_o, vao, fa, la;
  logic [1:0] lena;
  logic [31:0] dataa;
  logic [7:0] dao;
  // DUT B: els 4, hi-to-lo
  logic vb, rdyb, rb_o, vbo, fb, lb;
  logic [1:0] lenb;
  logic [31:0] datab;
  logic [7:0] dbo;
  // DUT C: els 1
  logic vc, rdyc, rc_o, vco, fc, lc;
  logic [0:0] lenc;
  logic [7:0] datac;
  logic [7:0] dco;

  int n_pass = 0;
  int n_total = 0;

  bsg_parallel_in_serial_out_passthrough_dynamic #(.width_p(8), .els_p(4), .hi_to_lo_p(1'b0)) dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(va), .len_i(lena), .data_i(dataa),
    .ready_and_o(ra_o), .v_o(vao), .data_o(dao), .first_o(fa), .last_o(la), .ready_and_i(rdya));

  bsg_parallel_in_serial_out_passthrough_dynamic #(.width_p(8), .els_p(4), .hi_to_lo_p(1'b1)) dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(vb), .len_i(lenb), .data_i(datab),
    .ready_and_o(rb_o), .v_o(vbo), .data_o(dbo), .first_o(fb), .last_o(lb), .ready_and_i(rdyb));

  bsg_parallel_in_serial_out_passthrough_dynamic #(.width_p(8), .els_p(1), .hi_to_lo_p(1'b0)) dut_c (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(vc), .len_i(lenc), .data_i(datac),
    .ready_and_o(rc_o), .v_o(vco), .data_o(dco), .first_o(fc), .last_o(lc), .ready_and_i(rdyc));

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    va = 0; vb = 0; vc = 0;
    rdya = 1; rdyb = 1; rdyc = 1;
    lena = 0; lenb = 0; lenc = 0;
    dataa = '0; datab = '0; datac = '0;
    tick(); tick();
    #1;
    n_total++;
    if ({vao, fa, ra_o} !== 3'b010)
      $display("FAIL reset_a {v,first,rdy} got %b exp 010", {vao, fa, ra_o}); else n_pass++;
    n_total++;
    if ({vbo, fb, rb_o} !== 3'b010)
      $display("FAIL reset_b {v,first,rdy} got %b exp 010", {vbo, fb, rb_o}); else n_pass++;
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_full_lo_hi();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    va = 1; lena = 3; dataa = 32'h44332211; rdya = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++;
      if ({dao, fa, la, ra_o} !== {exp[k], k == 0, k == 3, k == 3})
        $display("FAIL full k=%0d {data,f,l,r} got %h %b%b%b exp %h %b%b%b", k,
                 dao, fa, la, ra_o, exp[k], k == 0, k == 3, k == 3);
      else n_pass++;
      tick();
    end
    va = 0;
  endtask

  task automatic test_reverse();
    logic [7:0] exp [3] = '{8'h33, 8'h22, 8'h11};
    vb = 1; lenb = 2; datab = 32'h44332211; rdyb = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++;
      if ({dbo, fb, lb, rb_o} !== {exp[k], k == 0, k == 2, k == 2})
        $display("FAIL reverse k=%0d {data,f,l,r} got %h %b%b%b exp %h %b%b%b", k,
                 dbo, fb, lb, rb_o, exp[k], k == 0, k == 2, k == 2);
      else n_pass++;
      tick();
    end
    vb = 0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [6] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44};
    logic rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    va = 1; lena = 3; dataa = 32'h44332211;
    for (int k = 0; k < 6; k++) begin
      rdya = rdy[k];
      #1;
      n_total++;
      if ({dao, fa, la, ra_o} !== {exp[k], k == 0, k == 5, k == 5})
        $display("FAIL backpressure k=%0d {data,f,l,r} got %h %b%b%b exp %h %b%b%b", k,
                 dao, fa, la, ra_o, exp[k], k == 0, k == 5, k == 5);
      else n_pass++;
      tick();
    end
    va = 0; rdya = 1;
  endtask

  task automatic test_single_back_to_back();
    va = 1; rdya = 1; lena = 0; dataa = 32'h000000AA;
    #1;
    n_total++;
    if ({dao, fa, la, ra_o} !== {8'hAA, 3'b111})
      $display("FAIL single {data,f,l,r} got %h %b%b%b exp aa 111", dao, fa, la, ra_o); else n_pass++;
    tick();
    lena = 1; dataa = 32'h0000B1B0;
    #1;
    n_total++;
    if ({dao, fa, la, ra_o} !== {8'hB0, 3'b100})
      $display("FAIL b2b_word0 {data,f,l,r} got %h %b%b%b exp b0 100", dao, fa, la, ra_o); else n_pass++;
    tick();
    #1;
    n_total++;
    if ({dao, fa, la, ra_o} !== {8'hB1, 3'b011})
      $display("FAIL b2b_word1 {data,f,l,r} got %h %b%b%b exp b1 011", dao, fa, la, ra_o); else n_pass++;
    tick();
    va = 0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    va = 1; lena = 3; dataa = 32'h44332211; rdya = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_total++;
      if ({dao, ra_o} !== {exp[k], 1'b0})
        $display("FAIL rstmid_pre k=%0d {data,r} got %h %b exp %h 0", k, dao, ra_o, exp[k]); else n_pass++;
      tick();
    end
    reset_i = 1; va = 0;
    tick();
    #1;
    n_total++;
    if ({vao, fa, ra_o} !== 3'b010)
      $display("FAIL rstmid_in_reset {v,f,r} got %b exp 010", {vao, fa, ra_o}); else n_pass++;
    reset_i = 0; va = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++;
      if ({dao, fa, la, ra_o} !== {exp[k], k == 0, k == 3, k == 3})
        $display("FAIL rstmid_replay k=%0d {data,f,l,r} got %h %b%b%b exp %h %b%b%b", k,
                 dao, fa, la, ra_o, exp[k], k == 0, k == 3, k == 3);
      else n_pass++;
      tick();
    end
    va = 0;
  endtask

  task automatic test_els1();
    vc = 1; lenc = 0; datac = 8'h5A;
    for (int k = 0; k < 6; k++) begin
      rdyc = (k % 2 == 0);
      #1;
      n_total++;
      if ({vco, dco, fc, lc, rc_o} !== {1'b1, 8'h5A, 1'b1, 1'b1, rdyc})
        $display("FAIL els1 k=%0d {v,data,f,l,r} got %b %h %b%b%b exp 1 5a 11%b", k,
                 vco, dco, fc, lc, rc_o, rdyc);
      else n_pass++;
      tick();
    end
    vc = 0;
  endtask

  // Each message becomes a queue of expected words in emission order;
  // one word is retired per accepted handshake.
  task automatic test_random();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int sent_a = 0;
    int sent_b = 0;
    int la_len, lb_len;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (qa.size() == 0) begin
        la_len = $urandom_range(0, 3);
        lena = 2'(la_len);
        dataa = $urandom;
        for (int k = 0; k <= la_len; k++) qa.push_back(dataa[8*k +: 8]);
        sent_a = 0;
      end
      if (qb.size() == 0) begin
        lb_len = $urandom_range(0, 3);
        lenb = 2'(lb_len);
        datab = $urandom;
        for (int k = lb_len; k >= 0; k--) qb.push_back(datab[8*k +: 8]);
        sent_b = 0;
      end
      va = 1; vb = 1;
      rdya = ($urandom_range(0, 3) != 0);
      rdyb = ($urandom_range(0, 3) != 0);
      #1;
      n_total++;
      if ({vao, dao, fa, la, ra_o} !== {1'b1, qa[0], sent_a == 0, qa.size() == 1, rdya && qa.size() == 1})
        $display("FAIL rand_a cyc=%0d {v,data,f,l,r} got %b %h %b%b%b exp 1 %h %b%b%b", cyc,
                 vao, dao, fa, la, ra_o, qa[0], sent_a == 0, qa.size() == 1, rdya && qa.size() == 1);
      else n_pass++;
      n_total++;
      if ({vbo, dbo, fb, lb, rb_o} !== {1'b1, qb[0], sent_b == 0, qb.size() == 1, rdyb && qb.size() == 1})
        $display("FAIL rand_b cyc=%0d {v,data,f,l,r} got %b %h %b%b%b exp 1 %h %b%b%b", cyc,
                 vbo, dbo, fb, lb, rb_o, qb[0], sent_b == 0, qb.size() == 1, rdyb && qb.size() == 1);
      else n_pass++;
      if (rdya) begin void'(qa.pop_front()); sent_a++; end
      if (rdyb) begin void'(qb.pop_front()); sent_b++; end
      tick();
    end
    va = 0; vb = 0;
  endtask

  initial begin
    test_reset();
    test_full_lo_hi();
    test_reverse();
    test_backpressure();
    test_single_back_to_back();
    test_reset_mid();
    test_els1();
    test_random();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
